ann_infer_sequencer: RTL and testbench

ANN_INFER_SEQUENCER -- requirements
Module: ann_infer_sequencer

---
 rtl/ann_infer_sequencer.sv | 179 +++++++++++++++++
 tb/tb_ann_infer_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ann_infer_sequencer.sv
// Sequences one dense-layer inference over external weight/bias ROMs and reports the arg-max neuron.
// Define ANN_ACC_SAT_EN to make accumulator additions saturate instead of wrapping.
module ann_infer_sequencer #(
  parameter int N_IN     = 784,
  parameter int N_OUT    = 10,
  parameter int WEIGHT_W = 16,
  parameter int ACC_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [N_IN-1:0]     image,
  output logic [12:0]         w_addr,
  input  logic [WEIGHT_W-1:0] w_data,
  output logic [3:0]          b_addr,
  input  logic [WEIGHT_W-1:0] b_data,
  output logic                busy,
  output logic                done,
  output logic [3:0]          class_idx,
  output logic [ACC_W-1:0]    class_score,
  output logic [N_OUT-1:0]    output_neurons
);

  localparam int IW = $clog2(N_IN + 1);
  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [3:0]    J_LAST = 4'(N_OUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_DRAIN, S_CMP, S_DONE} state_t;

  state_t                   state_q;
  logic [N_IN-1:0]          image_q;
  logic [N_IN-1:0]          pix_q;
  logic [IW-1:0]            i_q;
  logic [3:0]               j_q;
  logic [12:0]              wbase_q;
  logic [12:0]              w_addr_q;
  logic [3:0]               b_addr_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  best_q;
  logic [3:0]               best_idx_q;
  logic                     busy_q;
  logic                     done_q;
  logic [3:0]               class_idx_q;
  logic [ACC_W-1:0]         class_score_q;
  logic [N_OUT-1:0]         onehot_q;

  logic signed [ACC_W-1:0]  w_ext_d;
  logic signed [ACC_W-1:0]  b_ext_d;
  logic signed [ACC_W-1:0]  acc_sum_d;
  logic [N_OUT-1:0]         onehot_d;

  assign w_ext_d = ACC_W'($signed(w_data));
  assign b_ext_d = ACC_W'($signed(b_data));

`ifdef ANN_ACC_SAT_EN
  logic [ACC_W:0] acc_wide_d;
  always_comb begin
    acc_wide_d = {acc_q[ACC_W-1], acc_q} + {w_ext_d[ACC_W-1], w_ext_d};
    acc_sum_d  = acc_wide_d[ACC_W-1:0];
    // Sign of the extended sum disagrees with its truncation only on overflow.
    if (acc_wide_d[ACC_W] != acc_wide_d[ACC_W-1]) begin
      acc_sum_d = acc_wide_d[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  always_comb begin
    acc_sum_d = acc_q + w_ext_d;
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_onehot
      assign onehot_d[gi] = (best_idx_q == 4'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      image_q       <= '0;
      pix_q         <= '0;
      i_q           <= '0;
      j_q           <= '0;
      wbase_q       <= '0;
      w_addr_q      <= '0;
      b_addr_q      <= '0;
      acc_q         <= '0;
      best_q        <= '0;
      best_idx_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      class_idx_q   <= '0;
      class_score_q <= '0;
      onehot_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort && state_q != S_IDLE) begin
        state_q  <= S_IDLE;
        busy_q   <= 1'b0;
        w_addr_q <= '0;
        b_addr_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              image_q  <= image;
              j_q      <= '0;
              wbase_q  <= '0;
              b_addr_q <= '0;
              busy_q   <= 1'b1;
              state_q  <= S_BIAS;
            end
          end
          S_BIAS: begin
            b_addr_q <= '0;
            w_addr_q <= wbase_q;
            pix_q    <= image_q;
            i_q      <= '0;
            state_q  <= S_MAC;
          end
          S_MAC: begin
            // ROM data lags the address by one cycle: bias arrives at i=0, weight i-1 afterwards.
            if (i_q == '0) begin
              acc_q <= b_ext_d;
            end else begin
              if (pix_q[0]) acc_q <= acc_sum_d;
              pix_q <= pix_q >> 1;
            end
            if (i_q == I_LAST) begin
              w_addr_q <= '0;
              state_q  <= S_DRAIN;
            end else begin
              i_q      <= i_q + 1'b1;
              w_addr_q <= w_addr_q + 1'b1;
            end
          end
          S_DRAIN: begin
            if (pix_q[0]) acc_q <= acc_sum_d;
            state_q <= S_CMP;
          end
          S_CMP: begin
            if (j_q == '0 || acc_q > best_q) begin
              best_q     <= acc_q;
              best_idx_q <= j_q;
            end
            if (j_q == J_LAST) begin
              state_q <= S_DONE;
            end else begin
              j_q      <= j_q + 1'b1;
              b_addr_q <= j_q + 1'b1;
              wbase_q  <= wbase_q + 13'(N_IN);
              state_q  <= S_BIAS;
            end
          end
          S_DONE: begin
            done_q        <= 1'b1;
            busy_q        <= 1'b0;
            class_idx_q   <= best_idx_q;
            class_score_q <= best_q;
            onehot_q      <= onehot_d;
            state_q       <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign w_addr         = w_addr_q;
  assign b_addr         = b_addr_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign class_idx      = class_idx_q;
  assign class_score    = class_score_q;
  assign output_neurons = onehot_q;

endmodule

// File: tb/tb_ann_infer_sequencer.sv
// Directed bench: a default-size instance for the full-length scenarios and a
// small 16-bit instance for the vector table and the overflow behaviour.
module tb_ann_infer_sequencer;

  localparam int NI  = 784;
  localparam int NO  = 10;
  localparam int SNI = 4;
  localparam int SNO = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          start_b, abort_b;
  logic [NI-1:0] image_b;
  logic [12:0]   w_addr_b;
  logic [15:0]   w_data_b, b_data_b;
  logic [3:0]    b_addr_b, idx_b;
  logic          busy_b, done_b;
  logic [31:0]   score_b;
  logic [NO-1:0] on_b;

  logic           start_s, abort_s;
  logic [SNI-1:0] image_s;
  logic [12:0]    w_addr_s;
  logic [15:0]    w_data_s, b_data_s;
  logic [3:0]     b_addr_s, idx_s;
  logic           busy_s, done_s;
  logic [15:0]    score_s;
  logic [SNO-1:0] on_s;

  logic [15:0] wmem_b [0:NI*NO-1];
  logic [15:0] bmem_b [0:15];
  logic [15:0] wmem_s [0:15];
  logic [15:0] bmem_s [0:15];

  always @(posedge clk) begin
    w_data_b <= wmem_b[w_addr_b];
    b_data_b <= bmem_b[b_addr_b];
    w_data_s <= wmem_s[w_addr_s[3:0]];
    b_data_s <= bmem_s[b_addr_s];
  end

  ann_infer_sequencer #(.N_IN(NI), .N_OUT(NO), .WEIGHT_W(16), .ACC_W(32)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b), .image(image_b),
    .w_addr(w_addr_b), .w_data(w_data_b), .b_addr(b_addr_b), .b_data(b_data_b),
    .busy(busy_b), .done(done_b), .class_idx(idx_b), .class_score(score_b),
    .output_neurons(on_b));

  ann_infer_sequencer #(.N_IN(SNI), .N_OUT(SNO), .WEIGHT_W(16), .ACC_W(16)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .abort(abort_s), .image(image_s),
    .w_addr(w_addr_s), .w_data(w_data_s), .b_addr(b_addr_s), .b_data(b_data_s),
    .busy(busy_s), .done(done_s), .class_idx(idx_s), .class_score(score_s),
    .output_neurons(on_s));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]             img;
    logic [2:0][3:0][15:0]  w;
    logic [2:0][15:0]       b;
    logic [3:0]             eidx;
    logic [15:0]            escore;
  } vec_t;

  vec_t vec [7];

  task automatic load_big(input int mode);
    for (int a = 0; a < NI*NO; a++) begin
      case (mode)
        0: wmem_b[a] = 16'd0;
        1: wmem_b[a] = (a / NI == 3) ? 16'd1 : 16'd0;
        default: wmem_b[a] = 16'd5;
      endcase
    end
    for (int j = 0; j < 16; j++) bmem_b[j] = (mode == 0) ? 16'(j) : (mode == 1) ? 16'd0 : 16'd5;
  endtask

  task automatic run_big(input int abort_at, input int reset_at, input bit probe, output int cycles);
    cycles = 0;
    @(negedge clk); start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    check("busy_after_start", busy_b, 1);
    for (int k = 1; k <= 9000; k++) begin
      @(posedge clk); #1;
      if (done_b) begin cycles = k; break; end
      if (probe) begin
        if (k == 100) begin
          check("w_addr_i99", w_addr_b, 99);
          check("results_held", idx_b, 9);
          start_b = 1'b1;
          image_b = '0;
        end
        if (k == 101) start_b = 1'b0;
        if (k == 787) check("b_addr_j1", b_addr_b, 1);
        if (k == 788) check("w_addr_j1_i0", w_addr_b, 784);
        if (k == 7870) check("addr_zero_in_done", {w_addr_b, b_addr_b}, 0);
      end
      if (abort_at != 0) begin
        if (k == abort_at - 1) abort_b = 1'b1;
        if (k == abort_at) begin
          abort_b = 1'b0;
          check("busy_low_after_abort", busy_b, 0);
        end
        if (k == abort_at + 50) break;
      end
      if (reset_at != 0 && k == reset_at) begin
        #1 reset = 1'b1;
        #1;
        check("rst_mid_busy_done", {busy_b, done_b}, 0);
        check("rst_mid_idx", idx_b, 0);
        check("rst_mid_score", score_b, 0);
        check("rst_mid_onehot", on_b, 0);
        check("rst_mid_addr", {w_addr_b, b_addr_b}, 0);
        #1 reset = 1'b0;
        break;
      end
    end
    if (cycles != 0) begin
      @(posedge clk); #1;
      check("done_one_cycle", done_b, 0);
      check("busy_clear", busy_b, 0);
    end
  endtask

  task automatic run_small(output int cycles);
    cycles = 0;
    @(negedge clk); start_s = 1'b1;
    @(posedge clk); #1; start_s = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (done_s) begin cycles = k; break; end
    end
  endtask

  initial begin
    int c;
    logic [2:0] oh;

    vec[0].img = 4'b1111; vec[0].w = '0;
    vec[0].b = {16'd2, 16'd1, 16'd0}; vec[0].eidx = 4'd2; vec[0].escore = 16'd2;
    vec[1].img = 4'b0101;
    vec[1].w = {{16'd0, 16'd1, 16'd0, 16'd1}, {16'd50, 16'd3, 16'd50, 16'd0}, {16'd100, 16'd1, 16'd100, 16'd1}};
    vec[1].b = '0; vec[1].eidx = 4'd1; vec[1].escore = 16'd3;
    vec[2].img = 4'b1111;
    vec[2].w = {{4{16'd0}}, {4{16'hFFFE}}, {4{16'hFFFF}}};
    vec[2].b = {16'hFFFB, 16'd10, 16'd0}; vec[2].eidx = 4'd1; vec[2].escore = 16'd2;
    vec[3].img = 4'b0000; vec[3].w = {12{16'd9}};
    vec[3].b = {16'hFFFD, 16'hFFF9, 16'hFFFD}; vec[3].eidx = 4'd0; vec[3].escore = 16'hFFFD;
    vec[4].img = 4'b0000; vec[4].w = {12{16'd9}};
    vec[4].b = {16'd5, 16'd5, 16'd1}; vec[4].eidx = 4'd1; vec[4].escore = 16'd5;
    vec[5].img = 4'b1000;
    vec[5].w = {{16'd6, 16'd20, 16'd20, 16'd20}, {16'hFFF9, 16'd20, 16'd20, 16'd20}, {16'd7, 16'd20, 16'd20, 16'd20}};
    vec[5].b = '0; vec[5].eidx = 4'd0; vec[5].escore = 16'd7;
    vec[6].img = 4'b0001;
    vec[6].w = {{16'd50, 16'd50, 16'd50, 16'hFFFF}, {16'd50, 16'd50, 16'd50, 16'd4}, {16'd50, 16'd50, 16'd50, 16'd3}};
    vec[6].b = '0; vec[6].eidx = 4'd1; vec[6].escore = 16'd4;

    reset = 1'b1;
    start_b = 1'b0; abort_b = 1'b0; image_b = '0;
    start_s = 1'b0; abort_s = 1'b0; image_s = '0;
    load_big(0);
    for (int a = 0; a < 16; a++) begin wmem_s[a] = '0; bmem_s[a] = '0; end
    #12;
    check("rst_busy_done", {busy_b, done_b}, 0);
    check("rst_idx_score", {idx_b, score_b}, 0);
    check("rst_onehot", on_b, 0);
    check("rst_addr", {w_addr_b, b_addr_b}, 0);
    @(negedge clk); reset = 1'b0;

    // zero weights, bias j: last neuron wins
    load_big(0);
    for (int i = 0; i < NI; i++) image_b[i] = 1'($urandom_range(0, 1));
    run_big(0, 0, 1'b0, c);
    $display("[TB] bias-only run: cycles=%0d idx=%0d score=%0d", c, idx_b, score_b);
    check("bias_done_cycle", c, 7871);
    check("bias_idx", idx_b, 9);
    check("bias_score", score_b, 9);
    check("bias_onehot", on_b, 10'b1000000000);

    // neuron 3 has unit weights; image cleared by an ignored start mid-run
    load_big(1);
    image_b = '1;
    run_big(0, 0, 1'b1, c);
    $display("[TB] neuron3 run: cycles=%0d idx=%0d score=%0d", c, idx_b, score_b);
    check("n3_done_cycle", c, 7871);
    check("n3_idx", idx_b, 3);
    check("n3_score", score_b, 784);
    check("n3_onehot", on_b, 10'b0000001000);

    // all equal: tie keeps neuron 0
    load_big(2);
    image_b = '1;
    run_big(0, 0, 1'b0, c);
    $display("[TB] tie run: cycles=%0d idx=%0d score=%0d", c, idx_b, score_b);
    check("tie_done_cycle", c, 7871);
    check("tie_idx", idx_b, 0);
    check("tie_score", score_b, 5 * 785);
    check("tie_onehot", on_b, 10'b0000000001);

    // abort at cycle 2000, then abort+start together in idle, then a clean rerun
    load_big(0);
    run_big(2000, 0, 1'b0, c);
    $display("[TB] abort run: done_cycle=%0d idx=%0d score=%0d", c, idx_b, score_b);
    check("abort_no_done", c, 0);
    check("abort_idx_kept", idx_b, 0);
    check("abort_score_kept", score_b, 5 * 785);
    @(negedge clk); start_b = 1'b1; abort_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0; abort_b = 1'b0;
    check("abort_wins_idle", busy_b, 0);
    run_big(0, 0, 1'b0, c);
    $display("[TB] post-abort run: cycles=%0d idx=%0d score=%0d", c, idx_b, score_b);
    check("rerun_done_cycle", c, 7871);
    check("rerun_idx", idx_b, 9);

    // async reset mid-inference, start on the first edge after release
    load_big(1);
    image_b = '1;
    run_big(0, 4000, 1'b0, c);
    $display("[TB] reset mid-run at cycle 4000");
    run_big(0, 0, 1'b0, c);
    $display("[TB] post-reset run: cycles=%0d idx=%0d score=%0d", c, idx_b, score_b);
    check("postrst_done_cycle", c, 7871);
    check("postrst_idx", idx_b, 3);
    check("postrst_score", score_b, 784);

    for (int v = 0; v < 7; v++) begin
      for (int j = 0; j < SNO; j++) begin
        for (int i = 0; i < SNI; i++) wmem_s[j*SNI + i] = vec[v].w[j][i];
        bmem_s[j] = vec[v].b[j];
      end
      image_s = vec[v].img;
      run_small(c);
      oh = '0;
      oh[vec[v].eidx[1:0]] = 1'b1;
      $display("[TB] vec %0d: cycles=%0d idx=%0d score=%0h", v, c, idx_s, score_s);
      check("vec_done_cycle", c, 22);
      check("vec_idx", idx_s, vec[v].eidx);
      check("vec_score", score_s, vec[v].escore);
      check("vec_onehot", on_s, oh);
    end

    // 5 x 0x7FFF overflows a 16-bit accumulator
    for (int a = 0; a < 16; a++) begin wmem_s[a] = 16'h7FFF; bmem_s[a] = 16'h7FFF; end
    image_s = '1;
    run_small(c);
    $display("[TB] overflow run: cycles=%0d idx=%0d score=%0h", c, idx_s, score_s);
    check("ovf_idx", idx_s, 0);
`ifdef ANN_ACC_SAT_EN
    check("ovf_score_sat", score_s, 16'h7FFF);
`else
    check("ovf_score_wrap", score_s, 16'h7FFB);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
